keypad_scan: RTL

4x4 matrix keypad scanner. It is the input-side counterpart of the seven-segment scan path: it drives one keypad row low at a time, reads the active-low columns back, debounces them, and emits a 4-bit key code with a one-cycle valid pulse. Downstream consumers are the mode/setting FSMs and the BCD preset counters, which receive keypad digits in place of pushbuttons.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_tick_gen.sv | 26 ++
 rtl/keypad_scan.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encoding,
// row-drive reset pattern, key-code width and a low-bit index helper.
package keypad_pkg;

    localparam int KEY_W = 4;

    localparam logic [1:0] ST_SCAN      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Index of the lowest zero bit; all-ones maps to 3 (caller gates on hit).
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running prescaler counting 0..SCAN_DIV-1; tick marks the last count.
// Ports: clk, rst_n (async active-low) in; tick (1-cycle strobe) out.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == W'(SCAN_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and key-valid pulse.
// Ports: clk, rst_n, col_n[3:0] in; row_n[3:0], key_code[3:0], key_valid,
// key_down, key_long out. Define KEYPAD_LONGPUSH_EN to build the long-press flag.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int LONG_SAMPLES   = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       col_n,
    output logic [3:0]       row_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down,
    output logic             key_long
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic             tick;
    logic [3:0]       col_s1_q, col_s2_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       row_n_q, row_n_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;
    logic             hit;
    logic [KEY_W-1:0] samp_code;
    logic [3:0]       row_next;
    logic             accept, release_done;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        hit       = ~&col_s2_q;
        samp_code = {low_idx(row_n_q), low_idx(col_s2_q)};
        row_next  = {row_n_q[2:0], row_n_q[3]};
        cnt_inc   = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + CW'(1);

        state_d      = state_q;
        row_n_d      = row_n_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_down_d   = key_down_q;
        accept       = 1'b0;
        release_done = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (hit) begin
                        cand_d = samp_code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) accept = 1'b1;
                        else                     state_d = ST_DEB_PRESS;
                    end else begin
                        row_n_d = row_next;
                    end
                end
                ST_DEB_PRESS: begin
                    if (hit && samp_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) accept = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                        row_n_d = row_next;
                    end
                end
                ST_HELD: begin
                    // Any hit keeps the key held, even a different column.
                    if (!hit) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE_SCANS == 1) release_done = 1'b1;
                        else                     state_d = ST_DEB_REL;
                    end
                end
                ST_DEB_REL: begin
                    if (hit) begin
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) release_done = 1'b1;
                    end
                end
            endcase
        end

        if (accept) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = ST_HELD;
        end
        if (release_done) begin
            key_down_d = 1'b0;
            row_n_d    = row_next;
            state_d    = ST_SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            state_q     <= ST_SCAN;
            row_n_q     <= ROW_RESET;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            col_s1_q    <= col_n;
            col_s2_q    <= col_s1_q;
            state_q     <= state_d;
            row_n_q     <= row_n_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

`ifdef KEYPAD_LONGPUSH_EN
    localparam int HW = $clog2(LONG_SAMPLES + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          key_long_q, key_long_d;

    always_comb begin
        hold_d     = hold_q;
        key_long_d = key_long_q;
        if (accept) begin
            hold_d = '0;
        end else if (tick && (state_q == ST_HELD || state_q == ST_DEB_REL)) begin
            hold_d = (hold_q == HW'(LONG_SAMPLES)) ? hold_q : hold_q + HW'(1);
            if (hold_d == HW'(LONG_SAMPLES)) key_long_d = 1'b1;
        end
        if (release_done) key_long_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            key_long_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            key_long_q <= key_long_d;
        end
    end

    assign key_long = key_long_q;
`else
    assign key_long = 1'b0;
`endif

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
